// File: rtl/risc_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// risc_register_file : 32x32 register file, two handshaked read ports, one write port
// Revision 1.0
// ============================================================================
module risc_register_file #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  i_rd_addr_a,
   input  logic        i_rd_addr_a_valid,
   output logic [31:0] o_rd_data_a,
   output logic        o_rd_data_a_ack,
   input  logic [4:0]  i_rd_addr_b,
   input  logic        i_rd_addr_b_valid,
   output logic [31:0] o_rd_data_b,
   output logic        o_rd_data_b_ack,
   input  logic        i_wr_en,
   input  logic [4:0]  i_wr_addr,
   input  logic [31:0] i_wr_data,
   output logic        o_wr_ack
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_ACK  = 2'd2;
   localparam logic [1:0] c_HOLD = 2'd3;
   localparam logic [3:0] c_CNT_LOAD = 4'(READ_LATENCY - 1);

   logic [31:0] r_mem [32];
   logic        r_wr_ack;

   logic [4:0]  w_req_addr  [2];
   logic [1:0]  w_req_valid;
   logic [31:0] w_port_data [2];
   logic [1:0]  w_port_ack;

   assign w_req_addr[0] = i_rd_addr_a;
   assign w_req_addr[1] = i_rd_addr_b;
   assign w_req_valid   = {i_rd_addr_b_valid, i_rd_addr_a_valid};

   // Entry 0 is never written; reads of index 0 are forced to zero below.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ack <= 1'b0;
      end else begin
         if (i_wr_en && (i_wr_addr != 5'd0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
         end
         r_wr_ack <= i_wr_en;
      end
   end

   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [1:0]  r_state;
         logic [1:0]  w_state_nxt;
         logic [3:0]  r_cnt;
         logic [4:0]  r_addr;
         logic [31:0] r_data;
         logic [4:0]  w_sel_addr;
         logic [31:0] w_rd_val;

         always_comb begin
            w_state_nxt = r_state;
            case (r_state)
               c_IDLE:  if (w_req_valid[p]) w_state_nxt = (READ_LATENCY == 1) ? c_ACK : c_WAIT;
               c_WAIT:  if (r_cnt == 4'd1) w_state_nxt = c_ACK;
               c_ACK:   w_state_nxt = w_req_valid[p] ? c_HOLD : c_IDLE;
               c_HOLD:  if (!w_req_valid[p]) w_state_nxt = c_IDLE;
               default: w_state_nxt = c_IDLE;
            endcase
         end

         // With single-cycle latency the address is used in the same cycle it is latched.
         assign w_sel_addr = (r_state == c_IDLE) ? w_req_addr[p] : r_addr;

         // Write-first: a write landing on the capture edge is what the reader sees.
         always_comb begin
            w_rd_val = '0;
            if (w_sel_addr != 5'd0) begin
               if (i_wr_en && (i_wr_addr == w_sel_addr)) begin
                  w_rd_val = i_wr_data;
               end else begin
                  w_rd_val = r_mem[w_sel_addr];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               r_state <= c_IDLE;
               r_cnt   <= '0;
               r_addr  <= '0;
               r_data  <= '0;
            end else begin
               r_state <= w_state_nxt;
               if ((r_state == c_IDLE) && w_req_valid[p]) begin
                  r_addr <= w_req_addr[p];
                  r_cnt  <= c_CNT_LOAD;
               end else if (r_state == c_WAIT) begin
                  r_cnt <= r_cnt - 4'd1;
               end
               if (w_state_nxt == c_ACK) begin
                  r_data <= w_rd_val;
               end
            end
         end

         assign w_port_data[p] = r_data;
         assign w_port_ack[p]  = (r_state == c_ACK);
      end
   endgenerate

   assign o_rd_data_a     = w_port_data[0];
   assign o_rd_data_a_ack = w_port_ack[0];
   assign o_rd_data_b     = w_port_data[1];
   assign o_rd_data_b_ack = w_port_ack[1];
   assign o_wr_ack        = r_wr_ack;

endmodule
`default_nettype wire

// File: doc/risc_register_file.md
# risc_register_file

Architectural register file (x0–x31, 32 bits each) that answers the instruction handler's two read-request ports and accepts result writes from the ALU. It is the responder side of the `reg_rd_addr_*_valid` / `reg_rd_data_*_ack` handshake. It sits between the instruction handler (read requests) and the ALU write-back path (`alu_reg_out` / `alu_reg_addr`). x0 is hardwired to zero.

## Interface
- READ_LATENCY, 1: cycles from the first cycle `rd_addr_*_valid` is high to the ack cycle; legal range 1–15.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_addr_a  in  5  port A register index
- rd_addr_a_valid  in  1  port A request; held high by initiator until ack seen
- rd_data_a  out  32  port A read data, valid in ack cycle, held until next ack
- rd_data_a_ack  out  1  port A one-cycle completion pulse
- rd_addr_b, rd_addr_b_valid, rd_data_b, rd_data_b_ack: identical, port B
- wr_en  in  1  write request from ALU write-back, one-cycle pulse
- wr_addr  in  5  destination index
- wr_data  in  32  value to write
- wr_ack  out  1  one-cycle pulse, cycle after an accepted wr_en

## Operation
- Storage: 32×32 array; reset clears all entries to 0. Reads of x0 always return 0; writes to x0 are discarded but still acked.
- Each read port has an independent FSM: IDLE, WAIT, ACK, HOLD.
  - IDLE: on `valid`=1, latch address, load counter with READ_LATENCY−1; go to ACK if READ_LATENCY=1, else WAIT.
  - WAIT: decrement; at 1 go to ACK.
  - ACK: `ack`=1 for exactly this cycle; go to HOLD.
  - HOLD: wait for `valid`=0, then go to IDLE. Prevents re-ack of a request still high in the cycle after ack. A request with valid low in the ACK cycle goes straight ACK→IDLE.
- Address is latched at IDLE→WAIT/ACK. Address changes while busy are ignored.
- Read data is sampled from the array at the clock edge entering ACK. If a write to the same non-zero index is accepted at that same edge, the new `wr_data` is returned (write-first bypass).
- Write: when `wr_en`=1, the array entry updates at that edge, and `wr_ack`=1 the next cycle. Writes are accepted every cycle with no back-pressure.
- Both ports issued in the same cycle with equal latency ack in the same cycle. This is required because the handler waits for coincident A and B acks on R-type instructions.
- Both ports may read the same index simultaneously; each gets an identical value.

## Timing
- Reset values: rd_data_a/b = 0, rd_data_a/b_ack = 0, wr_ack = 0, both FSMs IDLE, counters 0.
- Reset asserted mid-transaction: pending reads are abandoned with no ack, and pending wr_ack is dropped. After reset deasserts, a still-high valid is treated as a new request.
- Latency: valid first high in cycle N → ack in cycle N+READ_LATENCY.
- Minimum spacing between two requests on one port: READ_LATENCY+1 cycles (IDLE re-entry).
- A write at edge E is visible to any read whose ACK-entry edge is ≥ E.

## Test plan
- Reset, then read x0 and x5 on A/B with READ_LATENCY=1 → both acks in cycle N+1, data 0 and 0, single-cycle pulses.
- Write x5=0xDEADBEEF → wr_ack next cycle. Then A reads x5 and B reads x0 simultaneously → coincident acks, A=0xDEADBEEF, B=0.
- Write x0=0x12345678, then read x0 → 0; wr_ack still pulses.
- Hold valid high 3 cycles past ack → exactly one ack. Drop and re-raise valid → second ack with fresh data.
- READ_LATENCY=3: request x7 in cycle N, write x7=0xA5A5A5A5 at the ACK-entry edge → ack in cycle N+3 with 0xA5A5A5A5 (bypass).
- Assert reset during WAIT → no ack. After release, valid still high → ack READ_LATENCY cycles later, data 0 (array cleared).
